// File: rtl/fp32_add_pipe.sv
// fp32_add_pipe: three-stage IEEE-754 single-precision adder with valid/ready
// flow control and a sideband tag. S1 unpacks and aligns, S2 adds or
// subtracts, S3 normalises, rounds (nearest-even) and holds the result.
// Subnormals are flushed to zero on input and on output.
module fp32_add_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      sum,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q, s1_sign_d;
    logic [7:0]       s1_exp_q, s1_exp_d;
    logic [26:0]      s1_big_q, s1_big_d;
    logic [26:0]      s1_small_q, s1_small_d;
    logic             s1_sub_q, s1_sub_d;
    logic             s1_spec_q, s1_spec_d;
    logic [31:0]      s1_spec_val_q, s1_spec_val_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic             s2_sign_q, s2_sign_d;
    logic [7:0]       s2_exp_q, s2_exp_d;
    logic [27:0]      s2_sum_q, s2_sum_d;
    logic             s2_spec_q, s2_spec_d;
    logic [31:0]      s2_spec_val_q, s2_spec_val_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             s3_valid_q, s3_valid_d;
    logic [31:0]      sum_q, sum_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    // Stage load enables: a stage takes new content when it is empty or
    // its current content is moving on, so bubbles collapse.
    logic s1_en, s2_en, s3_en;

    // Load enables chained back from the consumer handshake
    always_comb begin
        s3_en = ~s3_valid_q | out_ready;
        s2_en = ~s2_valid_q | s3_en;
        s1_en = ~s1_valid_q | s2_en;
    end

    assign in_ready  = s1_en;
    assign out_valid = s3_valid_q;
    assign sum       = sum_q;
    assign out_tag   = out_tag_q;

    // ------------------------------------------------------------------
    // S1: unpack, classify, swap, align
    // ------------------------------------------------------------------
    logic        a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    logic [30:0] a_mag, b_mag;
    logic        swap;
    logic [31:0] big_op, small_op;
    logic        big_zero, small_zero;
    logic [7:0]  exp_diff;
    logic [26:0] small_full, small_shifted, lost_mask, aligned;
    logic        spec, spec_zero;
    logic [31:0] spec_val;

    // Operand classification, magnitude swap and alignment shift
    always_comb begin
        a_zero = (op_a[30:23] == 8'd0);
        b_zero = (op_b[30:23] == 8'd0);
        a_nan  = (&op_a[30:23]) & (|op_a[22:0]);
        b_nan  = (&op_b[30:23]) & (|op_b[22:0]);
        a_inf  = (&op_a[30:23]) & ~(|op_a[22:0]);
        b_inf  = (&op_b[30:23]) & ~(|op_b[22:0]);
        // Subnormals count as zero magnitude so they never win the swap
        a_mag  = a_zero ? 31'd0 : op_a[30:0];
        b_mag  = b_zero ? 31'd0 : op_b[30:0];
        swap   = (b_mag > a_mag);

        big_op     = swap ? op_b : op_a;
        small_op   = swap ? op_a : op_b;
        big_zero   = swap ? b_zero : a_zero;
        small_zero = swap ? a_zero : b_zero;

        exp_diff   = big_op[30:23] - small_op[30:23];
        small_full = small_zero ? 27'd0 : {1'b1, small_op[22:0], 3'b000};
        lost_mask  = ~(27'h7FF_FFFF << exp_diff[4:0]);
        small_shifted = small_full >> exp_diff[4:0];
        if (exp_diff >= 8'd26) begin
            // Nothing of B lands above the sticky position
            aligned = {26'd0, |small_full};
        end else begin
            aligned = small_shifted | {26'd0, |(small_full & lost_mask)};
        end

        // Special results bypass the datapath and ride along to S3
        spec_zero = a_zero & b_zero;
        spec      = 1'b0;
        spec_val  = 32'd0;
        if (a_nan | b_nan | (a_inf & b_inf & (op_a[31] ^ op_b[31]))) begin
            spec     = 1'b1;
            spec_val = CANON_NAN;
        end else if (a_inf) begin
            spec     = 1'b1;
            spec_val = op_a;
        end else if (b_inf) begin
            spec     = 1'b1;
            spec_val = op_b;
        end else if (spec_zero) begin
            spec     = 1'b1;
            spec_val = {op_a[31] & op_b[31], 31'd0};
        end
    end

    // S1 next-state: load a new operation on accept, otherwise hold
    always_comb begin
        s1_valid_d    = s1_en ? in_valid : s1_valid_q;
        s1_sign_d     = s1_sign_q;
        s1_exp_d      = s1_exp_q;
        s1_big_d      = s1_big_q;
        s1_small_d    = s1_small_q;
        s1_sub_d      = s1_sub_q;
        s1_spec_d     = s1_spec_q;
        s1_spec_val_d = s1_spec_val_q;
        s1_tag_d      = s1_tag_q;
        if (s1_en && in_valid) begin
            s1_sign_d     = big_op[31];
            s1_exp_d      = big_op[30:23];
            s1_big_d      = big_zero ? 27'd0 : {1'b1, big_op[22:0], 3'b000};
            s1_small_d    = aligned;
            s1_sub_d      = op_a[31] ^ op_b[31];
            s1_spec_d     = spec;
            s1_spec_val_d = spec_val;
            s1_tag_d      = in_tag;
        end
    end

    // ------------------------------------------------------------------
    // S2: magnitude add or subtract (non-negative thanks to the swap)
    // ------------------------------------------------------------------
    // S2 next-state: compute the 28-bit sum when S1 moves forward
    always_comb begin
        s2_valid_d    = s2_en ? s1_valid_q : s2_valid_q;
        s2_sign_d     = s2_sign_q;
        s2_exp_d      = s2_exp_q;
        s2_sum_d      = s2_sum_q;
        s2_spec_d     = s2_spec_q;
        s2_spec_val_d = s2_spec_val_q;
        s2_tag_d      = s2_tag_q;
        if (s2_en && s1_valid_q) begin
            s2_sign_d     = s1_sign_q;
            s2_exp_d      = s1_exp_q;
            s2_sum_d      = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                                     : ({1'b0, s1_big_q} + {1'b0, s1_small_q});
            s2_spec_d     = s1_spec_q;
            s2_spec_val_d = s1_spec_val_q;
            s2_tag_d      = s1_tag_q;
        end
    end

    // ------------------------------------------------------------------
    // S3: normalise, round to nearest-even, pack
    // ------------------------------------------------------------------
    logic [4:0]        lzc;
    logic [26:0]       norm;
    logic signed [9:0] exp_n, exp_r;
    logic              round_up;
    logic [24:0]       man_r;
    logic [22:0]       frac;
    logic [31:0]       result;

    // Normalisation, rounding and overflow/underflow handling
    always_comb begin
        lzc = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (s2_sum_q[i]) begin
                lzc = 5'(26 - i);
            end
        end

        if (s2_sum_q[27]) begin
            // Carry-out: shift right one, folding the lost bit into sticky
            norm  = {s2_sum_q[27:2], s2_sum_q[1] | s2_sum_q[0]};
            exp_n = $signed({2'b00, s2_exp_q}) + 10'sd1;
        end else begin
            norm  = s2_sum_q[26:0] << lzc;
            exp_n = $signed({2'b00, s2_exp_q}) - $signed({5'd0, lzc});
        end

        // Bits [2:0] are guard, round, sticky; bit 3 is the result LSB
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        man_r    = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (man_r[24]) begin
            exp_r = exp_n + 10'sd1;
            frac  = man_r[23:1];
        end else begin
            exp_r = exp_n;
            frac  = man_r[22:0];
        end

        if (s2_spec_q) begin
            result = s2_spec_val_q;
        end else if (s2_sum_q == 28'd0) begin
            result = 32'd0;
        end else if (exp_r >= 10'sd255) begin
            result = {s2_sign_q, 8'hFF, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            result = {s2_sign_q, 31'd0};
        end else begin
            result = {s2_sign_q, exp_r[7:0], frac};
        end
    end

    // S3 next-state: output register loads only real results so it holds
    always_comb begin
        s3_valid_d = s3_en ? s2_valid_q : s3_valid_q;
        sum_d      = sum_q;
        out_tag_d  = out_tag_q;
        if (s3_en && s2_valid_q) begin
            sum_d     = result;
            out_tag_d = s2_tag_q;
        end
    end

    // All pipeline state, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_exp_q      <= 8'd0;
            s1_big_q      <= 27'd0;
            s1_small_q    <= 27'd0;
            s1_sub_q      <= 1'b0;
            s1_spec_q     <= 1'b0;
            s1_spec_val_q <= 32'd0;
            s1_tag_q      <= '0;
            s2_valid_q    <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_exp_q      <= 8'd0;
            s2_sum_q      <= 28'd0;
            s2_spec_q     <= 1'b0;
            s2_spec_val_q <= 32'd0;
            s2_tag_q      <= '0;
            s3_valid_q    <= 1'b0;
            sum_q         <= 32'd0;
            out_tag_q     <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sign_q     <= s1_sign_d;
            s1_exp_q      <= s1_exp_d;
            s1_big_q      <= s1_big_d;
            s1_small_q    <= s1_small_d;
            s1_sub_q      <= s1_sub_d;
            s1_spec_q     <= s1_spec_d;
            s1_spec_val_q <= s1_spec_val_d;
            s1_tag_q      <= s1_tag_d;
            s2_valid_q    <= s2_valid_d;
            s2_sign_q     <= s2_sign_d;
            s2_exp_q      <= s2_exp_d;
            s2_sum_q      <= s2_sum_d;
            s2_spec_q     <= s2_spec_d;
            s2_spec_val_q <= s2_spec_val_d;
            s2_tag_q      <= s2_tag_d;
            s3_valid_q    <= s3_valid_d;
            sum_q         <= sum_d;
            out_tag_q     <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_fp32_add_pipe.sv
// tb_fp32_add_pipe: directed vectors with hand-computed sums, a stalled
// stream through the same table, and an asynchronous reset mid-stream.
module tb_fp32_add_pipe;

    localparam int TAG_W = 4;
    localparam int NV    = 20;

    // Operand pairs and hand-computed sums
    localparam logic [31:0] VEC_A [NV] = '{
        32'h3F800000, 32'h40490FDB, 32'h80000000, 32'h00000001, 32'h7F7FFFFF,
        32'h7F800000, 32'h7FC00001, 32'h4B800000, 32'h4B800001, 32'h3F800000,
        32'h3F800000, 32'h40400000, 32'h3F000000, 32'hC0A00000, 32'h7F800000,
        32'h00800000, 32'hFF800000, 32'h00000000, 32'h80000000, 32'h3F800000};
    localparam logic [31:0] VEC_B [NV] = '{
        32'h3F800000, 32'hC0490FDB, 32'h80000000, 32'h00000000, 32'h7F7FFFFF,
        32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hB3800000,
        32'h40000000, 32'hBF800000, 32'h3E800000, 32'h40400000, 32'h3F800000,
        32'h80800001, 32'hFF800000, 32'h80000000, 32'h3F800000, 32'hBF800000};
    localparam logic [31:0] VEC_S [NV] = '{
        32'h40000000, 32'h00000000, 32'h80000000, 32'h00000000, 32'h7F800000,
        32'h7FC00000, 32'h7FC00000, 32'h4B800000, 32'h4B800002, 32'h3F7FFFFF,
        32'h40400000, 32'h40000000, 32'h3F400000, 32'hC0000000, 32'h7F800000,
        32'h80000000, 32'hFF800000, 32'h00000000, 32'h3F800000, 32'h00000000};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      sum;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int errors = 0;

    fp32_add_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One operation on an idle pipe with out_ready held high
    task automatic run_op(input int idx);
        int lat;
        op_a      = VEC_A[idx];
        op_b      = VEC_B[idx];
        in_tag    = TAG_W'(idx);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq($sformatf("v%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq($sformatf("v%0d_latency", idx), 32'(lat), 32'd3);
        check_eq($sformatf("v%0d_sum", idx), sum, VEC_S[idx]);
        check_eq($sformatf("v%0d_tag", idx), {28'd0, out_tag}, 32'(idx % 16));
        $display("op %0d: %h + %h -> %h tag %0d latency %0d",
                 idx, VEC_A[idx], VEC_B[idx], sum, out_tag, lat);
        @(posedge clk); #1;
        check_eq($sformatf("v%0d_retired", idx), {31'd0, out_valid}, 32'd0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        int got;
        int cyc;
        int stale;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        in_tag    = '0;

        // Reset state
        #12;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_sum", sum, 32'd0);
        check_eq("rst_out_tag", {28'd0, out_tag}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors, one at a time
        for (int i = 0; i < NV; i++) begin
            run_op(i);
        end

        // Back-to-back stream with random back-pressure
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < NV && cyc < 2000) begin
            in_valid = (sent < NV);
            if (sent < NV) begin
                op_a   = VEC_A[sent];
                op_b   = VEC_B[sent];
                in_tag = TAG_W'(sent);
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (out_valid) begin
                check_eq($sformatf("stream%0d_sum", got), sum, VEC_S[got]);
                check_eq($sformatf("stream%0d_tag", got), {28'd0, out_tag}, 32'(got % 16));
                if (out_ready) begin
                    $display("stream result %0d: sum %h tag %0d", got, sum, out_tag);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("stream_count", 32'(got), 32'(NV));
        out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check_eq("stream_extra_beats", 32'(stale), 32'd0);

        // Asynchronous reset with three operations in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            op_a     = VEC_A[10 + k];
            op_b     = VEC_B[10 + k];
            in_tag   = TAG_W'(10 + k);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("inflight_valid", {31'd0, out_valid}, 32'd1);
        check_eq("inflight_sum", sum, VEC_S[10]);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("async_rst_sum", sum, 32'd0);
        check_eq("async_rst_tag", {28'd0, out_tag}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check_eq("rst2_stale", 32'(stale), 32'd0);
        run_op(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
